arrolhador: RTL and testbench
=============================

Name: arrolhador

Overview:
- Corking station at the end of the bottling line, directly downstream of the cork stock/dispenser block.
- Waits for a filled bottle and checks that corks are on the line (line cork count from the stock block).
- Drives the corking actuator for a fixed time, then pulses `done` to the stock block so it decrements its line count.
- Releases the conveyor, waits for the bottle to leave, and keeps a count of sealed bottles.

Parameters:
- TEMPO_VEDACAO, 4: cycles the corking actuator is held; values 0 and 1 both give 1 cycle.
- TEMPO_LIBERACAO, 2: cycles the conveyor release is held.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- garrafa_cheia  input  1  filled bottle present under the corker (level).
- CONTAGEM_ROLHAS_LINHA  input  8  corks currently on the line, from the stock block.
- ACIONAR_VEDADOR  output  1  corking actuator drive.
- done  output  1  one-cycle pulse: one cork consumed.
- LIBERAR_ESTEIRA  output  1  conveyor release drive.
- ALERTA_SEM_ROLHA  output  1  bottle waiting with no corks on the line.
- CONTAGEM_GARRAFAS_VEDADAS  output  8  sealed-bottle counter.
- ESTADO  output  2  current state: IDLE=0, ESPERA_ROLHA=1, VEDANDO=2, LIBERANDO=3.

Behaviour:
- All outputs are registered and change only on the rising clk edge. `reset` is sampled on the clock edge only.
- Reset: ESTADO=IDLE, 8-bit timer=0, every output=0, counter=0. Reset in any state aborts the operation at once with no `done` pulse; reset wins over every other input.
- IDLE:
  - garrafa_cheia=1 and CONTAGEM_ROLHAS_LINHA>0 → VEDANDO, timer=TEMPO_VEDACAO-1.
  - garrafa_cheia=1 and CONTAGEM_ROLHAS_LINHA=0 → ESPERA_ROLHA.
  - otherwise stay in IDLE.
- ESPERA_ROLHA:
  - ALERTA_SEM_ROLHA=1 while in this state.
  - CONTAGEM_ROLHAS_LINHA>0 → VEDANDO (timer loaded as above).
  - garrafa_cheia drops → IDLE, alert cleared.
- VEDANDO:
  - ACIONAR_VEDADOR=1 for exactly TEMPO_VEDACAO cycles, starting at the edge that enters the state. Timer decrements each cycle.
  - At timer=0: → LIBERANDO, timer=TEMPO_LIBERACAO-1 (0 if the parameter is 0), `done`=1 for exactly one cycle, counter+1.
  - The counter saturates at 255 and does not wrap.
  - garrafa_cheia is ignored while in VEDANDO; the cork is committed once sealing starts.
- LIBERANDO:
  - LIBERAR_ESTEIRA=1 until the timer expires; decrement each cycle.
  - After expiry, release drops and the block stays in LIBERANDO until garrafa_cheia=0, then → IDLE. This prevents double-corking a bottle that has not yet left.
- At most one `done` per bottle. `done` is never asserted outside the VEDANDO→LIBERANDO transition.
- Mutual exclusion: ACIONAR_VEDADOR and LIBERAR_ESTEIRA are never high in the same cycle.

Optional Feature:
- Macro: VERIFICA_VEDACAO_EN.
- Defined:
  - Adds input `rolha_ok` (1 bit), output `REJEITAR_GARRAFA` (1 bit) and output `CONTAGEM_REJEITADAS` (8 bit, saturating at 255); new signals reset to 0.
  - `rolha_ok` is sampled on the last VEDANDO cycle.
  - If `rolha_ok`=0: `done` still pulses (cork was consumed), REJEITAR_GARRAFA pulses in the same cycle, CONTAGEM_REJEITADAS+1, and CONTAGEM_GARRAFAS_VEDADAS is not incremented.
- Undefined: these ports are absent, and every seal counts as good.

Test Plan:
- Reset, CONTAGEM_ROLHAS_LINHA=10, garrafa_cheia=1 at edge N → ACIONAR_VEDADOR high edges N..N+3; `done` and LIBERAR_ESTEIRA high at N+4; `done` low at N+5; LIBERAR_ESTEIRA low at N+6; counter=1.
- garrafa_cheia=1, CONTAGEM_ROLHAS_LINHA=0 for 5 cycles, then 3 → ALERTA_SEM_ROLHA high for those 5 cycles and low on entering VEDANDO; then the normal sequence with a single `done`.
- Hold garrafa_cheia=1 for 20 cycles after a seal → ESTADO stays 3 with no second `done`; drop garrafa_cheia → ESTADO=0 next edge.
- Assert reset during VEDANDO cycle 2 → next edge: all outputs 0, ESTADO=0, counter=0, no `done` pulse.
- Run 257 bottles back to back → CONTAGEM_GARRAFAS_VEDADAS stays at 255; exactly 257 `done` pulses.
- With VERIFICA_VEDACAO_EN, rolha_ok=0 on the last seal cycle → `done`=1 and REJEITAR_GARRAFA=1 in the same cycle; rejected=1, sealed unchanged.

Source files
------------

// File: rtl/arrolhador_if.sv
// Signal bundle between the corking station and the line: bottle sensing, cork stock and drives.
// With VERIFICA_VEDACAO_EN defined it also carries the seal-check input and the reject outputs.
interface arrolhador_if;
    logic       garrafa_cheia;
    logic [7:0] CONTAGEM_ROLHAS_LINHA;
    logic       ACIONAR_VEDADOR;
    logic       done;
    logic       LIBERAR_ESTEIRA;
    logic       ALERTA_SEM_ROLHA;
    logic [7:0] CONTAGEM_GARRAFAS_VEDADAS;
    logic [1:0] ESTADO;
`ifdef VERIFICA_VEDACAO_EN
    logic       rolha_ok;
    logic       REJEITAR_GARRAFA;
    logic [7:0] CONTAGEM_REJEITADAS;
`endif

    modport master (
`ifdef VERIFICA_VEDACAO_EN
        output rolha_ok,
        input  REJEITAR_GARRAFA,
        input  CONTAGEM_REJEITADAS,
`endif
        output garrafa_cheia,
        output CONTAGEM_ROLHAS_LINHA,
        input  ACIONAR_VEDADOR,
        input  done,
        input  LIBERAR_ESTEIRA,
        input  ALERTA_SEM_ROLHA,
        input  CONTAGEM_GARRAFAS_VEDADAS,
        input  ESTADO
    );

    modport slave (
`ifdef VERIFICA_VEDACAO_EN
        input  rolha_ok,
        output REJEITAR_GARRAFA,
        output CONTAGEM_REJEITADAS,
`endif
        input  garrafa_cheia,
        input  CONTAGEM_ROLHAS_LINHA,
        output ACIONAR_VEDADOR,
        output done,
        output LIBERAR_ESTEIRA,
        output ALERTA_SEM_ROLHA,
        output CONTAGEM_GARRAFAS_VEDADAS,
        output ESTADO
    );
endinterface

// File: rtl/arrolhador.sv
// Corking station: waits for a filled bottle and corks on the line, seals it, pulses done, releases the conveyor.
// Optional seal verification and reject counting is enabled with VERIFICA_VEDACAO_EN.
module arrolhador #(
    parameter int unsigned TEMPO_VEDACAO   = 4,
    parameter int unsigned TEMPO_LIBERACAO = 2
) (
    input  logic        clk,
    input  logic        reset,
    arrolhador_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        ESPERA_ROLHA = 2'd1,
        VEDANDO      = 2'd2,
        LIBERANDO    = 2'd3
    } estado_t;

    localparam logic [7:0] CARGA_VEDACAO   = (TEMPO_VEDACAO > 1)   ? 8'(TEMPO_VEDACAO - 1)   : 8'd0;
    localparam logic [7:0] CARGA_LIBERACAO = (TEMPO_LIBERACAO > 0) ? 8'(TEMPO_LIBERACAO - 1) : 8'd0;
    localparam logic       LIBERA_ATIVA    = (TEMPO_LIBERACAO > 0);

    estado_t    estado_q,  estado_d;
    logic [7:0] timer_q,   timer_d;
    logic       vedador_q, vedador_d;
    logic       done_q,    done_d;
    logic       liberar_q, liberar_d;
    logic       alerta_q,  alerta_d;
    logic [7:0] vedadas_q, vedadas_d;
`ifdef VERIFICA_VEDACAO_EN
    logic       rejeitar_q,   rejeitar_d;
    logic [7:0] rejeitadas_q, rejeitadas_d;
`endif

    // Next-state, timer, counter and output computation
    always_comb begin
        estado_d  = estado_q;
        timer_d   = timer_q;
        done_d    = 1'b0;
        liberar_d = 1'b0;
        vedadas_d = vedadas_q;
`ifdef VERIFICA_VEDACAO_EN
        rejeitar_d   = 1'b0;
        rejeitadas_d = rejeitadas_q;
`endif
        case (estado_q)
            IDLE: begin
                if (bus.garrafa_cheia) begin
                    if (bus.CONTAGEM_ROLHAS_LINHA != 8'd0) begin
                        estado_d = VEDANDO;
                        timer_d  = CARGA_VEDACAO;
                    end else begin
                        estado_d = ESPERA_ROLHA;
                    end
                end else begin
                    estado_d = IDLE;
                end
            end
            ESPERA_ROLHA: begin
                if (!bus.garrafa_cheia) begin
                    estado_d = IDLE;
                end else if (bus.CONTAGEM_ROLHAS_LINHA != 8'd0) begin
                    estado_d = VEDANDO;
                    timer_d  = CARGA_VEDACAO;
                end else begin
                    estado_d = ESPERA_ROLHA;
                end
            end
            VEDANDO: begin
                if (timer_q == 8'd0) begin
                    estado_d  = LIBERANDO;
                    timer_d   = CARGA_LIBERACAO;
                    done_d    = 1'b1;
                    liberar_d = LIBERA_ATIVA;
`ifdef VERIFICA_VEDACAO_EN
                    // The cork is consumed either way; only a good seal counts as sealed.
                    if (bus.rolha_ok) begin
                        if (vedadas_q != 8'hFF) begin
                            vedadas_d = vedadas_q + 8'd1;
                        end else begin
                            vedadas_d = vedadas_q;
                        end
                    end else begin
                        rejeitar_d = 1'b1;
                        if (rejeitadas_q != 8'hFF) begin
                            rejeitadas_d = rejeitadas_q + 8'd1;
                        end else begin
                            rejeitadas_d = rejeitadas_q;
                        end
                    end
`else
                    if (vedadas_q != 8'hFF) begin
                        vedadas_d = vedadas_q + 8'd1;
                    end else begin
                        vedadas_d = vedadas_q;
                    end
`endif
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            LIBERANDO: begin
                if (timer_q != 8'd0) begin
                    timer_d   = timer_q - 8'd1;
                    liberar_d = 1'b1;
                end else if (!bus.garrafa_cheia) begin
                    estado_d = IDLE;
                end else begin
                    // Bottle still present: hold here so it is not corked twice.
                    estado_d = LIBERANDO;
                end
            end
            default: begin
                estado_d = IDLE;
                timer_d  = 8'd0;
            end
        endcase
        vedador_d = (estado_d == VEDANDO);
        alerta_d  = (estado_d == ESPERA_ROLHA);
    end

    // State and registered-output update with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q  <= IDLE;
            timer_q   <= 8'd0;
            vedador_q <= 1'b0;
            done_q    <= 1'b0;
            liberar_q <= 1'b0;
            alerta_q  <= 1'b0;
            vedadas_q <= 8'd0;
`ifdef VERIFICA_VEDACAO_EN
            rejeitar_q   <= 1'b0;
            rejeitadas_q <= 8'd0;
`endif
        end else begin
            estado_q  <= estado_d;
            timer_q   <= timer_d;
            vedador_q <= vedador_d;
            done_q    <= done_d;
            liberar_q <= liberar_d;
            alerta_q  <= alerta_d;
            vedadas_q <= vedadas_d;
`ifdef VERIFICA_VEDACAO_EN
            rejeitar_q   <= rejeitar_d;
            rejeitadas_q <= rejeitadas_d;
`endif
        end
    end

    assign bus.ACIONAR_VEDADOR           = vedador_q;
    assign bus.done                      = done_q;
    assign bus.LIBERAR_ESTEIRA           = liberar_q;
    assign bus.ALERTA_SEM_ROLHA          = alerta_q;
    assign bus.CONTAGEM_GARRAFAS_VEDADAS = vedadas_q;
    assign bus.ESTADO                    = estado_q;
`ifdef VERIFICA_VEDACAO_EN
    assign bus.REJEITAR_GARRAFA          = rejeitar_q;
    assign bus.CONTAGEM_REJEITADAS       = rejeitadas_q;
`endif

endmodule

// File: tb/tb_arrolhador.sv
// Self-checking bench for arrolhador: expected counter/reject values are queued per bottle and matched on each done pulse.
module tb_arrolhador;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   done_cnt;
    logic [7:0] exp_cnt;
    logic [8:0] exp_q[$];

    arrolhador_if bus();

    arrolhador #(.TEMPO_VEDACAO(4), .TEMPO_LIBERACAO(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue the expected outcome of one bottle entering the sealer.
    task automatic push_bottle(input logic rejeita);
        if (!rejeita && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        exp_q.push_back({rejeita, exp_cnt});
    endtask

    task automatic wait_released();
        int n;
        n = 0;
        while (!(bus.ESTADO == 2'd3 && !bus.LIBERAR_ESTEIRA) && n < 50) begin
            step();
            n++;
        end
        check_value("liberado_estado", 32'(bus.ESTADO), 32'd3);
    endtask

    // Per-cycle monitor: mutual exclusion and scoreboard match on every done pulse.
    always @(negedge clk) begin
        logic [8:0] e;
        check_value("mutex_vedador_esteira", 32'(bus.ACIONAR_VEDADOR & bus.LIBERAR_ESTEIRA), 32'd0);
        if (bus.done) begin
            done_cnt++;
            check_value("done_esperado", 32'(exp_q.size() > 0), 32'd1);
            check_value("done_estado", 32'(bus.ESTADO), 32'd3);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_value("contagem_vedadas", 32'(bus.CONTAGEM_GARRAFAS_VEDADAS), 32'(e[7:0]));
`ifdef VERIFICA_VEDACAO_EN
                check_value("rejeitar_pulso", 32'(bus.REJEITAR_GARRAFA), 32'(e[8]));
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        n_checks = 0;
        n_errors = 0;
        done_cnt = 0;
        exp_cnt  = 8'd0;
        reset = 1'b1;
        bus.garrafa_cheia = 1'b0;
        bus.CONTAGEM_ROLHAS_LINHA = 8'd0;
`ifdef VERIFICA_VEDACAO_EN
        bus.rolha_ok = 1'b1;
`endif
        step();
        step();
        check_value("reset_estado", 32'(bus.ESTADO), 32'd0);
        check_value("reset_vedador", 32'(bus.ACIONAR_VEDADOR), 32'd0);
        check_value("reset_done", 32'(bus.done), 32'd0);
        check_value("reset_esteira", 32'(bus.LIBERAR_ESTEIRA), 32'd0);
        check_value("reset_alerta", 32'(bus.ALERTA_SEM_ROLHA), 32'd0);
        check_value("reset_contagem", 32'(bus.CONTAGEM_GARRAFAS_VEDADAS), 32'd0);
        reset = 1'b0;
        step();

        // Basic seal timing
        bus.garrafa_cheia = 1'b1;
        bus.CONTAGEM_ROLHAS_LINHA = 8'd10;
        push_bottle(1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_value("vedando_vedador", 32'(bus.ACIONAR_VEDADOR), 32'd1);
            check_value("vedando_estado", 32'(bus.ESTADO), 32'd2);
            check_value("vedando_done", 32'(bus.done), 32'd0);
        end
        step();
        check_value("fim_done", 32'(bus.done), 32'd1);
        check_value("fim_esteira", 32'(bus.LIBERAR_ESTEIRA), 32'd1);
        check_value("fim_vedador", 32'(bus.ACIONAR_VEDADOR), 32'd0);
        check_value("fim_contagem", 32'(bus.CONTAGEM_GARRAFAS_VEDADAS), 32'd1);
        step();
        check_value("done_baixo", 32'(bus.done), 32'd0);
        check_value("esteira_ciclo2", 32'(bus.LIBERAR_ESTEIRA), 32'd1);
        step();
        check_value("esteira_baixa", 32'(bus.LIBERAR_ESTEIRA), 32'd0);
        check_value("liberando_estado", 32'(bus.ESTADO), 32'd3);

        // Bottle stays: no second done
        repeat (20) step();
        check_value("retido_estado", 32'(bus.ESTADO), 32'd3);
        check_value("retido_dones", 32'(done_cnt), 32'd1);
        bus.garrafa_cheia = 1'b0;
        step();
        check_value("saida_idle", 32'(bus.ESTADO), 32'd0);

        // No corks on the line, then corks arrive
        bus.garrafa_cheia = 1'b1;
        bus.CONTAGEM_ROLHAS_LINHA = 8'd0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_value("espera_alerta", 32'(bus.ALERTA_SEM_ROLHA), 32'd1);
            check_value("espera_estado", 32'(bus.ESTADO), 32'd1);
        end
        bus.CONTAGEM_ROLHAS_LINHA = 8'd3;
        push_bottle(1'b0);
        step();
        check_value("espera_sai_alerta", 32'(bus.ALERTA_SEM_ROLHA), 32'd0);
        check_value("espera_sai_estado", 32'(bus.ESTADO), 32'd2);
        wait_released();
        bus.garrafa_cheia = 1'b0;
        step();
        check_value("espera_dones", 32'(done_cnt), 32'd2);

        // Bottle removed while waiting for corks
        bus.garrafa_cheia = 1'b1;
        bus.CONTAGEM_ROLHAS_LINHA = 8'd0;
        step();
        check_value("aborta_alerta_on", 32'(bus.ALERTA_SEM_ROLHA), 32'd1);
        bus.garrafa_cheia = 1'b0;
        step();
        check_value("aborta_estado", 32'(bus.ESTADO), 32'd0);
        check_value("aborta_alerta_off", 32'(bus.ALERTA_SEM_ROLHA), 32'd0);

        // Reset in the middle of sealing
        bus.garrafa_cheia = 1'b1;
        bus.CONTAGEM_ROLHAS_LINHA = 8'd5;
        step();
        step();
        reset = 1'b1;
        bus.garrafa_cheia = 1'b0;
        step();
        exp_cnt = 8'd0;
        check_value("rst_vedando_estado", 32'(bus.ESTADO), 32'd0);
        check_value("rst_vedando_vedador", 32'(bus.ACIONAR_VEDADOR), 32'd0);
        check_value("rst_vedando_done", 32'(bus.done), 32'd0);
        check_value("rst_vedando_contagem", 32'(bus.CONTAGEM_GARRAFAS_VEDADAS), 32'd0);
        step();
        reset = 1'b0;
        step();
        check_value("rst_vedando_dones", 32'(done_cnt), 32'd2);

`ifdef VERIFICA_VEDACAO_EN
        // Failed seal: done and reject together, sealed count unchanged
        bus.rolha_ok = 1'b0;
        bus.garrafa_cheia = 1'b1;
        bus.CONTAGEM_ROLHAS_LINHA = 8'd4;
        push_bottle(1'b1);
        wait_released();
        bus.garrafa_cheia = 1'b0;
        bus.rolha_ok = 1'b1;
        step();
        check_value("rejeitadas", 32'(bus.CONTAGEM_REJEITADAS), 32'd1);
        check_value("rejeito_vedadas", 32'(bus.CONTAGEM_GARRAFAS_VEDADAS), 32'd0);
`endif

        // Back-to-back bottles up to counter saturation
        d0 = done_cnt;
        bus.CONTAGEM_ROLHAS_LINHA = 8'd10;
        for (int b = 0; b < 257; b++) begin
            bus.garrafa_cheia = 1'b1;
            push_bottle(1'b0);
            step();
            wait_released();
            bus.garrafa_cheia = 1'b0;
            step();
        end
        check_value("saturacao_contagem", 32'(bus.CONTAGEM_GARRAFAS_VEDADAS), 32'd255);
        check_value("saturacao_dones", 32'(done_cnt - d0), 32'd257);
        check_value("fila_vazia", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
